// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: store sizes, load types,
// FSM states and a small address-range helper.
package dmem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int CNT_W  = 4;

  // Store size carried on req_wbits.
  typedef enum logic [1:0] {
    WB_WORD = 2'b00,
    WB_HALF = 2'b01,
    WB_BYTE = 2'b10,
    WB_RSVD = 2'b11
  } wbits_e;

  // Load type carried on req_rbits; 101..111 are reserved.
  typedef enum logic [2:0] {
    RB_LW  = 3'b000,
    RB_LH  = 3'b001,
    RB_LHU = 3'b010,
    RB_LB  = 3'b011,
    RB_LBU = 3'b100
  } rbits_e;

  // Transaction FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // True when the word holding this byte address exists in a memory of depth words.
  function automatic logic word_in_range(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return word_idx < depth;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store byte enables and lane replication, load
// byte/half selection with sign or zero extension, and size/alignment faults.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic        we_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  wbits_i,
  input  logic [2:0]  rbits_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlanes_o,
  output logic [31:0] rdata_o,
  output logic        fault_o
);

  logic [31:0] byte_shift;
  logic [15:0] half_sel;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    logic signed [7:0] s;
    s = b;
    return 32'(s);
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    logic signed [15:0] s;
    s = h;
    return 32'(s);
  endfunction

  function automatic logic [31:0] zext8(input logic [7:0] b);
    return {24'h0, b};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] h);
    return {16'h0, h};
  endfunction

  // Little-endian: lane n holds bits [8n+7:8n] of the word.
  assign byte_shift = rword_i >> {addr_lo_i, 3'b000};
  assign half_sel   = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  // Decode the access size into lanes, load result and fault.
  always_comb begin
    be_o     = 4'b0000;
    wlanes_o = 32'h0;
    rdata_o  = 32'h0;
    fault_o  = 1'b0;
    if (we_i) begin
      case (wbits_i)
        WB_WORD: begin
          be_o     = 4'b1111;
          wlanes_o = wdata_i;
          fault_o  = (addr_lo_i != 2'b00);
        end
        WB_HALF: begin
          be_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wlanes_o = {2{wdata_i[15:0]}};
          fault_o  = addr_lo_i[0];
        end
        WB_BYTE: begin
          be_o     = 4'b0001 << addr_lo_i;
          wlanes_o = {4{wdata_i[7:0]}};
        end
        default: fault_o = 1'b1;
      endcase
    end else begin
      case (rbits_i)
        RB_LW: begin
          rdata_o = rword_i;
          fault_o = (addr_lo_i != 2'b00);
        end
        RB_LH: begin
          rdata_o = sext16(half_sel);
          fault_o = addr_lo_i[0];
        end
        RB_LHU: begin
          rdata_o = zext16(half_sel);
          fault_o = addr_lo_i[0];
        end
        RB_LB:   rdata_o = sext8(byte_shift[7:0]);
        RB_LBU:  rdata_o = zext8(byte_shift[7:0]);
        default: fault_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits a
// fixed number of cycles, commits the store and holds the response until taken.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_wbits,
  input  logic [2:0]  req_rbits,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               enter_resp;

  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [1:0]         wbits_q;
  logic [2:0]         rbits_q;

  logic               rsp_err_q;
  logic [31:0]        rsp_rdata_q;

  logic [WORD_W-1:0]  mem_q [DEPTH_WORDS];

  logic               in_idle;
  logic               accept;
  logic               cur_we;
  logic [31:0]        cur_addr;
  logic [31:0]        cur_wdata;
  logic [1:0]         cur_wbits;
  logic [2:0]         cur_rbits;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        rword;
  logic               in_range;
  logic [3:0]         be;
  logic [31:0]        wlanes;
  logic [31:0]        ld_data;
  logic               lane_fault;
  logic               acc_err;
  logic               commit;

  assign in_idle   = (state_q == ST_IDLE);
  assign req_ready = in_idle;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign accept    = req_valid & in_idle;

  // With zero wait states the access resolves on the accepting edge, before
  // the request fields are latched, so the live inputs are used in IDLE.
  assign cur_we    = in_idle ? req_we    : we_q;
  assign cur_addr  = in_idle ? req_addr  : addr_q;
  assign cur_wdata = in_idle ? req_wdata : wdata_q;
  assign cur_wbits = in_idle ? req_wbits : wbits_q;
  assign cur_rbits = in_idle ? req_rbits : rbits_q;

  assign idx      = cur_addr[IDX_W+1:2];
  assign in_range = word_in_range(cur_addr, DEPTH_WORDS);
  assign rword    = mem_q[idx];
  assign acc_err  = lane_fault | ~in_range;
  assign commit   = enter_resp & ~rst & cur_we & ~acc_err;

  dmem_lane_align u_align (
    .we_i      (cur_we),
    .addr_lo_i (cur_addr[1:0]),
    .wbits_i   (cur_wbits),
    .rbits_i   (cur_rbits),
    .wdata_i   (cur_wdata),
    .rword_i   (rword),
    .be_o      (be),
    .wlanes_o  (wlanes),
    .rdata_o   (ld_data),
    .fault_o   (lane_fault)
  );

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; enter_resp marks the edge on which the access resolves.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the request so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wbits_q <= req_wbits;
      rbits_q <= req_rbits;
    end
  end

  // Response registers, loaded once on RESP entry and held until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else if (enter_resp) begin
      rsp_err_q   <= acc_err;
      rsp_rdata_q <= (acc_err | cur_we) ? 32'h0 : ld_data;
    end
  end

  // Byte-masked store into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wlanes[8*i +: 8];
        end
      end
    end
  end

endmodule
